// File: rtl/image_rom_pkg.sv
// Shared definitions for the image ROM arbiter.
//   - Default ROM geometry: address width, pixel width, number of valid words.
//   - FSM state encoding and transaction owner encoding.
// No ports; imported by image_rom_arb_pick and image_rom_arbiter.
package image_rom_pkg;

   localparam int unsigned DefaultAddrW = 17;     // ROM word-address width
   localparam int unsigned DefaultDataW = 24;     // RGB888 pixel
   localparam int unsigned DefaultDepth = 90000;  // 300x300 image

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIssue   = 2'd1,
      StCapture = 2'd2
   } arb_state_e;

   typedef enum logic {
      OwnerA = 1'b0,
      OwnerB = 1'b1
   } owner_e;

endpackage

// File: rtl/image_rom_arb_pick.sv
// Winner selection for the two-requester image ROM arbiter.
// Purely combinational.
//   req_a_i, req_b_i : pending requests
//   prio_b_i         : 1 gives B precedence when both request, 0 gives A precedence
//   pick_o           : one-hot winner, bit 0 = A, bit 1 = B; all-zero when nobody requests
module image_rom_arb_pick
   import image_rom_pkg::*;
(
   input  logic       req_a_i,
   input  logic       req_b_i,
   input  logic       prio_b_i,
   output logic [1:0] pick_o
);

   always_comb begin
      pick_o = 2'b00;
      if (req_a_i && req_b_i) begin
         pick_o = prio_b_i ? 2'b10 : 2'b01;
      end else if (req_a_i) begin
         pick_o = 2'b01;
      end else if (req_b_i) begin
         pick_o = 2'b10;
      end
   end

endmodule

// File: rtl/image_rom_arbiter.sv
// Two-requester arbiter in front of a single-port image ROM with a registered read port.
// One transaction every three cycles: IDLE (arbitrate) -> ISSUE (ROM read) -> CAPTURE.
// The grant, ROM read and response all come from registers; the grant and the ROM read
// are visible during ISSUE, the response strobe in the cycle after CAPTURE.
// Addresses at or above DEPTH never reach the ROM and complete with data 0 and the error flag.
//
// Build option: define IMAGE_ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise A has fixed priority over B and there is no pointer register.
//
// Ports:
//   clock, reset_n             : clock, asynchronous active-low reset
//   req_a/b, addr_a/b          : requests, held until granted; address stable while req high
//   gnt_a/b                    : one-cycle grant pulse
//   rsp_valid_a/b              : one-cycle response strobe
//   rsp_data_a/b               : response pixel, held until the next response to that side
//   rsp_err_a/b                : out-of-range flag, meaningful with rsp_valid
//   rom_read_enable            : ROM read enable
//   rom_address                : ROM word address
//   rom_read_data              : ROM data, valid one edge after the read enable is sampled
module image_rom_arbiter
   import image_rom_pkg::*;
#(
   parameter int unsigned ADDR_W = DefaultAddrW,
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned DEPTH  = DefaultDepth
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   output logic              gnt_a,
   output logic              gnt_b,
   output logic              rsp_valid_a,
   output logic              rsp_valid_b,
   output logic [DATA_W-1:0] rsp_data_a,
   output logic [DATA_W-1:0] rsp_data_b,
   output logic              rsp_err_a,
   output logic              rsp_err_b,
   output logic              rom_read_enable,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [DATA_W-1:0] rom_read_data
);

   // One extra bit so the compare is exact at full address width, even when DEPTH is 2**ADDR_W.
   localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

   arb_state_e        state_q;
   owner_e            owner_q;
   logic              err_q;
   logic              prio_b;
   logic [1:0]        pick;
   logic [ADDR_W-1:0] sel_addr;
   logic              in_range;

`ifdef IMAGE_ROM_ARB_ROUND_ROBIN_EN
   // 1: B has precedence on the next simultaneous request (A was granted last).
   logic ptr_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= 1'b0;
      end else if (state_q == StIdle && pick != 2'b00) begin
         ptr_q <= pick[0];
      end
   end

   assign prio_b = ptr_q;
`else
   assign prio_b = 1'b0;
`endif

   image_rom_arb_pick u_pick (
      .req_a_i  (req_a),
      .req_b_i  (req_b),
      .prio_b_i (prio_b),
      .pick_o   (pick)
   );

   assign sel_addr = pick[1] ? addr_b : addr_a;
   assign in_range = ({1'b0, sel_addr} < DepthW);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= StIdle;
         owner_q         <= OwnerA;
         err_q           <= 1'b0;
         gnt_a           <= 1'b0;
         gnt_b           <= 1'b0;
         rsp_valid_a     <= 1'b0;
         rsp_valid_b     <= 1'b0;
         rsp_data_a      <= '0;
         rsp_data_b      <= '0;
         rsp_err_a       <= 1'b0;
         rsp_err_b       <= 1'b0;
         rom_read_enable <= 1'b0;
         rom_address     <= '0;
      end else begin
         // Pulses and the ROM command default low; data and error flags hold.
         gnt_a           <= 1'b0;
         gnt_b           <= 1'b0;
         rsp_valid_a     <= 1'b0;
         rsp_valid_b     <= 1'b0;
         rom_read_enable <= 1'b0;
         rom_address     <= '0;
         unique case (state_q)
            StIdle: begin
               if (pick != 2'b00) begin
                  gnt_a           <= pick[0];
                  gnt_b           <= pick[1];
                  owner_q         <= pick[1] ? OwnerB : OwnerA;
                  err_q           <= !in_range;
                  rom_read_enable <= in_range;
                  rom_address     <= in_range ? sel_addr : '0;
                  state_q         <= StIssue;
               end
            end
            StIssue: begin
               // ROM samples the read at the end of this cycle; data is valid during CAPTURE.
               state_q <= StCapture;
            end
            StCapture: begin
               if (owner_q == OwnerB) begin
                  rsp_valid_b <= 1'b1;
                  rsp_data_b  <= err_q ? '0 : rom_read_data;
                  rsp_err_b   <= err_q;
               end else begin
                  rsp_valid_a <= 1'b1;
                  rsp_data_a  <= err_q ? '0 : rom_read_data;
                  rsp_err_a   <= err_q;
               end
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
